row_lifting_stream: RTL and testbench

Streaming, parametrised CDF 5/3 (reversible integer lifting) row transformer for the wavelet datapath. It accepts one row of `LENGTH` unsigned samples over a valid/ready stream and emits `LENGTH/2` (s, d) coefficient pairs over a second valid/ready stream. The block supports output backpressure, row framing and error reporting on mis-framed rows. It replaces the fixed-width, array-fed row processor and the separate data-forming stage for column/row passes that need arbitrary width and length.

---
 rtl/row_lifting_stream.sv | 149 ++++++++++++++
 tb/tb_row_lifting_stream.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_lifting_stream.sv
// row_lifting_stream: streaming CDF 5/3 reversible lifting over one row.
// Consumes LENGTH unsigned samples, emits LENGTH/2 signed (s, d) pairs.
module row_lifting_stream #(
   parameter int DATA_W = 8,
   parameter int LENGTH = 512
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W+1:0] out_s,
   output logic [DATA_W+1:0] out_d,
   output logic              out_last,
   output logic              err
);

   localparam int OUT_W = DATA_W + 2;
   localparam int SW    = DATA_W + 3;
   localparam int IW    = $clog2(LENGTH);

   localparam logic [IW-1:0] LAST_I  = IW'(LENGTH - 1);
   localparam logic [IW-1:0] PAIR0_I = IW'(2);

   localparam logic [0:0] ST_FIRST = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   localparam logic signed [SW-1:0] RND = 2;

   logic [0:0]        st_q, st_d;
   logic [IW-1:0]     i_q, i_d;
   logic [DATA_W-1:0] xe_q, xe_d;
   logic [DATA_W-1:0] xo_q, xo_d;
   logic [OUT_W-1:0]  dp_q, dp_d;
   logic              ov_q, ov_d;
   logic [OUT_W-1:0]  s_q, s_d;
   logic [OUT_W-1:0]  d_q, d_d;
   logic              last_q, last_d;
   logic              err_q, err_d;

   logic acc, at_last, abort, emit;

   logic signed [SW-1:0]    xe_w, xo_w, xn_w;
   logic signed [SW-1:0]    sum_x, d_w, dl_w, sum_d;
   logic signed [OUT_W-1:0] s_w;

   assign in_ready  = resetn && (!ov_q || out_ready);
   assign out_valid = ov_q;
   assign out_s     = s_q;
   assign out_d     = d_q;
   assign out_last  = last_q;
   assign err       = err_q;

   // Lifting datapath; at the last index x[LENGTH] mirrors to x[LENGTH-2].
   always_comb begin
      xe_w = SW'(xe_q);
      if (at_last) begin
         xo_w = SW'(in_data);
         xn_w = xe_w;
      end else begin
         xo_w = SW'(xo_q);
         xn_w = SW'(in_data);
      end
      sum_x = xe_w + xn_w;
      d_w   = xo_w - (sum_x >>> 1);
      dl_w  = (i_q == PAIR0_I) ? d_w : {dp_q[OUT_W-1], dp_q};
      sum_d = dl_w + d_w + RND;
      s_w   = OUT_W'(xe_w + (sum_d >>> 2));
   end

   // Handshake, framing and next-state selection.
   always_comb begin
      acc     = in_valid && in_ready;
      at_last = (i_q == LAST_I);
      abort   = acc && in_last && !at_last;
      emit    = acc && !abort &&
                (at_last || (st_q == ST_RUN && !i_q[0]));

      st_d   = st_q;
      i_d    = i_q;
      xe_d   = xe_q;
      xo_d   = xo_q;
      dp_d   = dp_q;
      ov_d   = ov_q;
      s_d    = s_q;
      d_d    = d_q;
      last_d = last_q;
      err_d  = abort || (acc && at_last && !in_last);

      if (acc) begin
         unique case (1'b1)
            abort || at_last: begin
               i_d  = '0;
               st_d = ST_FIRST;
            end
            default: begin
               i_d  = i_q + IW'(1);
               st_d = ST_RUN;
            end
         endcase
      end

      if (acc && !abort && !i_q[0])
         xe_d = in_data;
      if (acc && !abort && i_q[0] && !at_last)
         xo_d = in_data;

      if (emit) begin
         dp_d   = d_w[OUT_W-1:0];
         ov_d   = 1'b1;
         s_d    = s_w;
         d_d    = d_w[OUT_W-1:0];
         last_d = at_last;
      end else if (out_ready) begin
         ov_d = 1'b0;
      end
   end

   // State, history and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         st_q   <= ST_FIRST;
         i_q    <= '0;
         xe_q   <= '0;
         xo_q   <= '0;
         dp_q   <= '0;
         ov_q   <= 1'b0;
         s_q    <= '0;
         d_q    <= '0;
         last_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         i_q    <= i_d;
         xe_q   <= xe_d;
         xo_q   <= xo_d;
         dp_q   <= dp_d;
         ov_q   <= ov_d;
         s_q    <= s_d;
         d_q    <= d_d;
         last_q <= last_d;
         err_q  <= err_d;
      end
   end

endmodule

// File: tb/tb_row_lifting_stream.sv
// tb_row_lifting_stream: table vectors on a LENGTH=4 instance,
// random rows against a lifting model on a LENGTH=8 instance.
module tb_row_lifting_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // LENGTH = 4 instance
   logic       rst4 = 1'b0;
   logic       in_valid4 = 1'b0, in_ready4, in_last4 = 1'b0;
   logic [7:0] in_data4 = '0;
   logic       out_valid4, out_last4, err4;
   logic       out_ready4 = 1'b1;
   logic [9:0] out_s4, out_d4;

   row_lifting_stream #(.DATA_W(8), .LENGTH(4)) u_l4 (
      .clk(clk), .resetn(rst4),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .in_data(in_data4), .in_last(in_last4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .out_s(out_s4), .out_d(out_d4),
      .out_last(out_last4), .err(err4)
   );

   // LENGTH = 8 instance
   logic       rst8 = 1'b0;
   logic       in_valid8 = 1'b0, in_ready8, in_last8 = 1'b0;
   logic [7:0] in_data8 = '0;
   logic       out_valid8, out_last8, err8;
   logic       out_ready8 = 1'b1;
   logic [9:0] out_s8, out_d8;

   row_lifting_stream #(.DATA_W(8), .LENGTH(8)) u_l8 (
      .clk(clk), .resetn(rst8),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .in_data(in_data8), .in_last(in_last8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .out_s(out_s8), .out_d(out_d8),
      .out_last(out_last8), .err(err8)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model (LENGTH = 8) ----------------
   typedef struct {
      int s;
      int d;
      int l;
   } pair_t;

   pair_t exp_q[$];
   int    row_x[8];
   int    pairs_seen = 0;
   int    err_seen = 0;
   int    err_exp = 0;
   int    stall_cnt = 0;
   int    stall_cyc = 0;

   function automatic int fl(input int a, input int b);
      return (a >= 0) ? a / b : -((-a + b - 1) / b);
   endfunction

   // push pairs whose triggering sample index is <= lim
   task automatic model_row(input int lim);
      int d[4];
      int xn, dm, s, trig;
      for (int n = 0; n < 4; n++) begin
         xn = (n < 3) ? row_x[2*n+2] : row_x[6];
         d[n] = row_x[2*n+1] - fl(row_x[2*n] + xn, 2);
      end
      for (int n = 0; n < 4; n++) begin
         dm = (n == 0) ? d[0] : d[n-1];
         s = row_x[2*n] + fl(dm + d[n] + 2, 4);
         trig = (n == 3) ? 7 : 2*n + 2;
         if (trig <= lim)
            exp_q.push_back('{s, d[n], (n == 3) ? 1 : 0});
      end
   endtask

   task automatic send8(input int x, input bit last);
      int n;
      n = 0;
      in_valid8 = 1'b1;
      in_data8 = 8'(x);
      in_last8 = last;
      forever begin
         @(negedge clk);
         if (in_ready8) begin
            @(posedge clk);
            #1;
            break;
         end
         stall_cnt++;
         n++;
         if (n > 300) begin
            checks++;
            errors++;
            $display("FAIL send timeout: in_ready stuck at 0");
            @(posedge clk);
            #1;
            break;
         end
      end
   endtask

   task automatic row8(input int nsend, input int last_at,
                       input int lim, input bit gaps);
      for (int k = 0; k < 8; k++)
         row_x[k] = ($urandom_range(0, 3) == 0) ?
                    255 * $urandom_range(0, 1) :
                    $urandom_range(0, 255);
      model_row(lim);
      for (int k = 0; k < nsend; k++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid8 = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         send8(row_x[k], k == last_at);
      end
   endtask

   task automatic drain();
      in_valid8 = 1'b0;
      for (int t = 0; t < 60 && exp_q.size() != 0; t++)
         @(posedge clk);
      #1;
      chk("drain pending pairs", exp_q.size(), 0);
   endtask

   // ---------------- output monitor (LENGTH = 8) ----------------
   initial begin
      pair_t p;
      bit    held;
      int    hs, hd, hl;
      held = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst8) begin
            held = 1'b0;
         end else begin
            if (held) begin
               chk("stall hold valid", int'(out_valid8), 1);
               if (out_valid8) begin
                  chk("stall hold s", int'($signed(out_s8)), hs);
                  chk("stall hold d", int'($signed(out_d8)), hd);
                  chk("stall hold last", int'(out_last8), hl);
               end
            end
            if (out_valid8 && out_ready8) begin
               pairs_seen++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected pair s=%0d d=%0d",
                           $signed(out_s8), $signed(out_d8));
               end else begin
                  p = exp_q.pop_front();
                  chk("pair s", int'($signed(out_s8)), p.s);
                  chk("pair d", int'($signed(out_d8)), p.d);
                  chk("pair last", int'(out_last8), p.l);
               end
            end
            if (out_valid8 && !out_ready8) begin
               chk("stall in_ready", int'(in_ready8), 0);
               held = 1'b1;
               hs = int'($signed(out_s8));
               hd = int'($signed(out_d8));
               hl = int'(out_last8);
               stall_cyc++;
            end else begin
               held = 1'b0;
            end
            if (err8)
               err_seen++;
         end
      end
   end

   // ---------------- table vectors (LENGTH = 4) ----------------
   typedef struct {
      int v, x, l;
      int ev, es, ed, el, ee;
   } vec_t;

   vec_t tbl[19];

   initial begin
      int base, sbase, b0;
      bit done;

      tbl[0]  = '{1, 10,  0, 0, 0,   0,    0, 0};
      tbl[1]  = '{1, 20,  0, 0, 0,   0,    0, 0};
      tbl[2]  = '{1, 30,  0, 1, 10,  0,    0, 0};
      tbl[3]  = '{1, 40,  1, 1, 33,  10,   1, 0};
      tbl[4]  = '{1, 0,   0, 0, 0,   0,    0, 0};
      tbl[5]  = '{1, 255, 0, 0, 0,   0,    0, 0};
      tbl[6]  = '{1, 0,   0, 1, 128, 255,  0, 0};
      tbl[7]  = '{1, 255, 1, 1, 128, 255,  1, 0};
      tbl[8]  = '{0, 0,   0, 0, 0,   0,    0, 0};
      tbl[9]  = '{1, 255, 0, 0, 0,   0,    0, 0};
      tbl[10] = '{1, 0,   0, 0, 0,   0,    0, 0};
      tbl[11] = '{1, 255, 0, 1, 128, -255, 0, 0};
      tbl[12] = '{1, 0,   1, 1, 128, -255, 1, 0};
      tbl[13] = '{1, 5,   1, 0, 0,   0,    0, 1};
      tbl[14] = '{0, 0,   0, 0, 0,   0,    0, 0};
      tbl[15] = '{1, 10,  0, 0, 0,   0,    0, 0};
      tbl[16] = '{1, 20,  0, 0, 0,   0,    0, 0};
      tbl[17] = '{1, 30,  0, 1, 10,  0,    0, 0};
      tbl[18] = '{1, 40,  0, 1, 33,  10,   1, 1};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset in_ready", int'(in_ready8), 0);
      chk("reset out_valid", int'(out_valid8), 0);
      chk("reset out_last", int'(out_last8), 0);
      chk("reset err", int'(err8), 0);
      chk("reset out_s", int'(out_s8), 0);
      chk("reset out_d", int'(out_d8), 0);
      chk("reset l4 in_ready", int'(in_ready4), 0);
      rst4 = 1'b1;
      rst8 = 1'b1;
      @(posedge clk);
      #1;

      for (int k = 0; k < 19; k++) begin
         in_valid4 = tbl[k].v[0];
         in_data4  = 8'(tbl[k].x);
         in_last4  = tbl[k].l[0];
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d valid", k), int'(out_valid4), tbl[k].ev);
         chk($sformatf("vec%0d err", k), int'(err4), tbl[k].ee);
         if (tbl[k].ev != 0) begin
            chk($sformatf("vec%0d s", k), int'($signed(out_s4)), tbl[k].es);
            chk($sformatf("vec%0d d", k), int'($signed(out_d4)), tbl[k].ed);
            chk($sformatf("vec%0d last", k), int'(out_last4), tbl[k].el);
         end
      end
      in_valid4 = 1'b0;

      // plain row
      row8(8, 7, 7, 1'b0);
      drain();

      // backpressure after the first pair
      base = pairs_seen;
      sbase = stall_cyc;
      fork
         row8(8, 7, 7, 1'b0);
         begin
            for (int t = 0; t < 100 && pairs_seen < base + 1; t++)
               @(posedge clk);
            #1;
            out_ready8 = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            out_ready8 = 1'b1;
         end
      join
      drain();
      chk("backpressure stall seen", int'(stall_cyc - sbase >= 2), 1);
      chk("backpressure pair count", pairs_seen - base, 4);

      // in_last on index 3 aborts the row
      base = pairs_seen;
      row8(4, 3, 2, 1'b0);
      err_exp++;
      chk("abort err pulse", int'(err8), 1);
      in_valid8 = 1'b0;
      @(posedge clk);
      #1;
      chk("abort err one cycle", int'(err8), 0);
      drain();
      chk("abort pair count", pairs_seen - base, 1);
      row8(8, 7, 7, 1'b0);
      drain();

      // two rows back to back, second without in_last
      b0 = stall_cnt;
      base = pairs_seen;
      row8(8, 7, 7, 1'b0);
      row8(8, -1, 7, 1'b0);
      err_exp++;
      chk("missing last err", int'(err8), 1);
      drain();
      chk("back-to-back bubbles", stall_cnt - b0, 0);
      chk("back-to-back pairs", pairs_seen - base, 8);

      // reset mid-row after 5 samples
      row8(5, -1, 3, 1'b0);
      rst8 = 1'b0;
      in_valid8 = 1'b0;
      #2;
      chk("midrow rst in_ready", int'(in_ready8), 0);
      chk("midrow rst out_valid", int'(out_valid8), 0);
      chk("midrow rst out_last", int'(out_last8), 0);
      chk("midrow rst err", int'(err8), 0);
      chk("midrow rst out_s", int'(out_s8), 0);
      chk("midrow rst out_d", int'(out_d8), 0);
      repeat (2) @(posedge clk);
      #1;
      rst8 = 1'b1;
      @(posedge clk);
      #1;
      row8(8, 7, 7, 1'b0);
      drain();

      // random gaps and random backpressure
      done = 1'b0;
      fork
         begin
            for (int r = 0; r < 6; r++)
               row8(8, 7, 7, 1'b1);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready8 = ($urandom_range(0, 3) != 0);
            end
            out_ready8 = 1'b1;
         end
      join
      drain();

      chk("err pulse count", err_seen, err_exp);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
